// File: rtl/ddr2_tg_pkg.sv
// Shared types and constants for the DDR2 write/read-back traffic generator.
package ddr2_tg_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrWait,
    StWrReq,
    StWrData,
    StRdWait,
    StRdReq,
    StRdData,
    StPassEnd,
    StDone
  } tg_state_e;

  typedef enum logic [1:0] {
    PAT_INC  = 2'd0,
    PAT_LFSR = 2'd1,
    PAT_WALK = 2'd2,
    PAT_INV  = 2'd3
  } pattern_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback taken from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/ddr2_traffic_gen_if.sv
// App-port handshake between the traffic generator (master) and the DDR2 controller (slave).
interface ddr2_traffic_gen_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_ack;
  logic                  wr_data_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, wr_data_req, rd_ack, rd_data_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, wr_data_req, rd_ack, rd_data_valid, rd_data
  );

endinterface

// File: rtl/ddr2_tg_pattern.sv
// Beat data generator: holds the pass-global beat index and LFSR state, emits the current beat.
module ddr2_tg_pattern
  import ddr2_tg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pattern_e              pattern,
  input  logic                  advance,
  input  logic                  restart,
  output logic [DATA_WIDTH-1:0] data
);

  logic [15:0] beat_q;
  logic [15:0] lfsr_q;

  // restart wins over advance so the last beat of a phase can rewind in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (restart) begin
      beat_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      beat_q <= beat_q + 16'd1;
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    data = '0;
    unique case (pattern)
      PAT_INC:  data = {(DATA_WIDTH / 16){beat_q}};
      PAT_LFSR: data = {(DATA_WIDTH / 16){lfsr_q}};
      PAT_WALK: data = DATA_WIDTH'(1) << (32'(beat_q) % DATA_WIDTH);
      PAT_INV:  data = ~{(DATA_WIDTH / 16){beat_q}};
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/ddr2_traffic_gen.sv
// Write/read-back traffic generator and checker for the DDR2 controller app port.
module ddr2_traffic_gen
  import ddr2_tg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned NUM_BURSTS = 64,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_STEP  = 16,
  parameter int unsigned WR_DELAY   = 100,
  parameter int unsigned RD_DELAY   = 200
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  init_done,
  input  logic [1:0]            pattern_sel,
  input  logic                  loop_en,
  ddr2_traffic_gen_if.master    app,
  output logic                  wr_over,
  output logic                  rd_error,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [15:0]           pass_cnt,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [7:0]            LastBeat = 8'(BURST_LEN - 1);
  localparam logic [31:0]           LastBurst = 32'(NUM_BURSTS - 1);

  tg_state_e             state_q, state_d;
  pattern_e              pattern_q, pattern_d;
  logic [31:0]           delay_q, delay_d;
  logic [31:0]           burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_over_q, wr_over_d;
  logic                  rd_error_q, rd_error_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic [15:0]           pass_cnt_q, pass_cnt_d;
  logic                  gen_restart, wr_advance, rd_advance;
  logic [DATA_WIDTH-1:0] wr_beat, exp_beat;

  ddr2_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wr_gen (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .pattern (pattern_q),
    .advance (wr_advance),
    .restart (gen_restart),
    .data    (wr_beat)
  );

  ddr2_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_exp_gen (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .pattern (pattern_q),
    .advance (rd_advance),
    .restart (gen_restart),
    .data    (exp_beat)
  );

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    delay_d     = '0;
    burst_d     = burst_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wr_over_d   = wr_over_q;
    rd_error_d  = rd_error_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_cnt_d  = pass_cnt_q;
    gen_restart = 1'b0;
    wr_advance  = 1'b0;
    rd_advance  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init_done) begin
          pattern_d   = pattern_e'(pattern_sel);
          burst_d     = '0;
          beat_d      = '0;
          addr_d      = BaseAddr;
          gen_restart = 1'b1;
          state_d     = StWrWait;
        end
      end
      StWrWait: begin
        if (delay_q == WR_DELAY) state_d = StWrReq;
        else                     delay_d = delay_q + 32'd1;
      end
      StWrReq: if (app.wr_ack) state_d = StWrData;
      StWrData: begin
        if (app.wr_data_req) begin
          wr_advance = 1'b1;
          beat_d     = beat_q + 8'd1;
          if (beat_q == LastBeat) begin
            beat_d = '0;
            if (burst_q == LastBurst) begin
              burst_d     = '0;
              addr_d      = BaseAddr;
              wr_over_d   = 1'b1;
              gen_restart = 1'b1;
              state_d     = StRdWait;
            end else begin
              burst_d = burst_q + 32'd1;
              addr_d  = addr_q + AddrStep;
              state_d = StWrReq;
            end
          end
        end
      end
      StRdWait: begin
        if (delay_q == RD_DELAY) state_d = StRdReq;
        else                     delay_d = delay_q + 32'd1;
      end
      StRdReq: if (app.rd_ack) state_d = StRdData;
      StRdData: begin
        if (app.rd_data_valid) begin
          rd_advance = 1'b1;
          if (app.rd_data != exp_beat) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            rd_error_d = 1'b1;
            if (!rd_error_q) first_err_d = addr_q;
          end
          beat_d = beat_q + 8'd1;
          if (beat_q == LastBeat) begin
            beat_d = '0;
            if (burst_q == LastBurst) begin
              state_d = StPassEnd;
            end else begin
              burst_d = burst_q + 32'd1;
              addr_d  = addr_q + AddrStep;
              state_d = StRdReq;
            end
          end
        end
      end
      StPassEnd: begin
        pass_cnt_d = pass_cnt_q + 16'd1;
        if (loop_en) begin
          pattern_d   = pattern_e'(pattern_sel);
          burst_d     = '0;
          beat_d      = '0;
          addr_d      = BaseAddr;
          gen_restart = 1'b1;
          state_d     = StWrWait;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      pattern_q   <= PAT_INC;
      delay_q     <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      addr_q      <= '0;
      wr_over_q   <= 1'b0;
      rd_error_q  <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      delay_q     <= delay_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      wr_over_q   <= wr_over_d;
      rd_error_q  <= rd_error_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

  assign app.wr_req      = (state_q == StWrReq);
  assign app.rd_req      = (state_q == StRdReq);
  assign app.wr_addr     = addr_q;
  assign app.rd_addr     = addr_q;
  assign app.wr_data     = wr_beat;
  assign wr_over         = wr_over_q;
  assign rd_error        = rd_error_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_addr  = first_err_q;
  assign pass_cnt        = pass_cnt_q;
  assign busy            = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Bench for ddr2_traffic_gen: directed passes against a controller responder and a beat model.
module tb_ddr2_traffic_gen;

  localparam int unsigned AW = 26, DW = 32, BL = 8, NB = 4;
  localparam int unsigned BASE = 0, STEP = 16, WRD = 3, RDD = 5;
  localparam int BEATS = BL * NB;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          init_done = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          loop_en = 1'b0;
  logic          wr_over, rd_error, busy;
  logic [15:0]   err_cnt, pass_cnt;
  logic [AW-1:0] first_err_addr;

  ddr2_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app ();

  ddr2_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(NB),
    .BASE_ADDR(BASE), .ADDR_STEP(STEP), .WR_DELAY(WRD), .RD_DELAY(RDD)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .init_done      (init_done),
    .pattern_sel    (pattern_sel),
    .loop_en        (loop_en),
    .app            (app),
    .wr_over        (wr_over),
    .rd_error       (rd_error),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .pass_cnt       (pass_cnt),
    .busy           (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected beat n of a pass, straight from the pattern definitions.
  function automatic logic [31:0] model_beat(input int pat, input int n);
    logic [15:0] nn;
    logic [15:0] s;
    nn = n[15:0];
    s  = 16'hACE1;
    case (pat)
      0: return {nn, nn};
      1: begin
        for (int i = 0; i < n; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return {s, s};
      end
      2: return 32'h1 << (n % 32);
      default: return ~{nn, nn};
    endcase
  endfunction

  // Model state shared between the responder and the compare process.
  int          pass_pat[$];
  int          wr_total, rd_total, wr_bursts, rd_bursts, model_err;
  bit          stray;
  logic [31:0] mem [BEATS];
  logic [31:0] cap [BEATS];
  logic [31:0] exp_d;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      wr_total = 0; rd_total = 0; wr_bursts = 0; rd_bursts = 0; model_err = 0;
    end else begin
      check("err_cnt_track", err_cnt, model_err);
      if (app.wr_req && app.wr_ack) begin
        check("wr_addr", app.wr_addr, BASE + (wr_bursts % NB) * STEP);
        wr_bursts++;
      end
      if (app.rd_req && app.rd_ack) begin
        check("rd_addr", app.rd_addr, BASE + (rd_bursts % NB) * STEP);
        rd_bursts++;
      end
      if (app.wr_data_req) begin
        exp_d = model_beat(pass_pat[wr_total / BEATS], wr_total % BEATS);
        check("wr_data", app.wr_data, exp_d);
        cap[wr_total % BEATS] = app.wr_data;
        mem[wr_total % BEATS] = app.wr_data;
        wr_total++;
      end
      if (app.rd_data_valid && !stray) begin
        exp_d = model_beat(pass_pat[rd_total / BEATS], rd_total % BEATS);
        if (app.rd_data !== exp_d && model_err < 65535) model_err++;
        rd_total++;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_req(input bit rd);
    int t = 0;
    while (((rd ? app.rd_req : app.wr_req) !== 1'b1) && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) check(rd ? "rd_req_timeout" : "wr_req_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) check("done_timeout", 0, 1);
  endtask

  task automatic serve_pass(input bit gaps, input int ack_dly, input int corrupt, input bit stray_en);
    int idx;
    for (int b = 0; b < NB; b++) begin
      wait_req(1'b0);
      repeat (ack_dly) tick();
      app.wr_ack = 1'b1; tick(); app.wr_ack = 1'b0;
      for (int i = 0; i < BL; i++) begin
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        app.wr_data_req = 1'b1; tick(); app.wr_data_req = 1'b0;
      end
    end
    if (stray_en) begin
      stray = 1'b1; app.rd_data = 32'hDEAD_BEEF; app.rd_data_valid = 1'b1;
      tick();
      app.rd_data_valid = 1'b0; stray = 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      wait_req(1'b1);
      repeat (ack_dly) tick();
      app.rd_ack = 1'b1; tick(); app.rd_ack = 1'b0;
      for (int i = 0; i < BL; i++) begin
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        idx = b * BL + i;
        app.rd_data = mem[idx] ^ ((idx == corrupt) ? 32'h8 : 32'h0);
        app.rd_data_valid = 1'b1; tick(); app.rd_data_valid = 1'b0;
      end
    end
  endtask

  task automatic start(input logic [1:0] pat, input bit loop);
    sys_rst = 1'b1;
    pattern_sel = pat;
    loop_en = loop;
    init_done = 1'b1;
    pass_pat.delete();
    pass_pat.push_back(int'(pat));
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_req"}, app.wr_req, 0);
    check({tag, "_rd_req"}, app.rd_req, 0);
    check({tag, "_wr_addr"}, app.wr_addr, 0);
    check({tag, "_rd_addr"}, app.rd_addr, 0);
    check({tag, "_wr_data"}, app.wr_data, 0);
    check({tag, "_wr_over"}, wr_over, 0);
    check({tag, "_rd_error"}, rd_error, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_first_err"}, first_err_addr, 0);
    check({tag, "_pass_cnt"}, pass_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    app.wr_ack = 1'b0; app.wr_data_req = 1'b0;
    app.rd_ack = 1'b0; app.rd_data_valid = 1'b0; app.rd_data = '0;
    stray = 1'b0;
    #12;
    check_zero("reset");

    // Pattern 0, ideal responder, stray read-valid while waiting to read.
    start(2'd0, 1'b0);
    serve_pass(1'b0, 0, -1, 1'b1);
    wait_done();
    check("p0_beat0", cap[0], 32'h0000_0000);
    check("p0_beat1", cap[1], 32'h0001_0001);
    check("p0_beat31", cap[31], 32'h001F_001F);
    check("p0_wr_over", wr_over, 1);
    check("p0_rd_error", rd_error, 0);
    check("p0_pass_cnt", pass_cnt, 1);
    repeat (20) tick();
    check("done_wr_req", app.wr_req, 0);
    check("done_busy", busy, 0);
    check("done_pass_cnt", pass_cnt, 1);

    // Pattern 1: LFSR states from the seed.
    start(2'd1, 1'b0);
    serve_pass(1'b0, 0, -1, 1'b0);
    wait_done();
    check("lfsr_beat0", cap[0], 32'hACE1_ACE1);
    check("lfsr_beat1", cap[1], 32'h5670_5670);
    check("lfsr_beat2", cap[2], 32'hAB38_AB38);
    check("lfsr_beat3", cap[3], 32'h559C_559C);
    check("lfsr_err_cnt", err_cnt, 0);
    check("lfsr_rd_error", rd_error, 0);

    // Pattern 3 with bit 3 of beat 2 in burst 1 corrupted on read.
    start(2'd3, 1'b0);
    serve_pass(1'b0, 0, BL + 2, 1'b0);
    wait_done();
    check("inv_beat10", cap[10], 32'hFFF5_FFF5);
    check("corrupt_err_cnt", err_cnt, 1);
    check("corrupt_rd_error", rd_error, 1);
    check("corrupt_first_addr", first_err_addr, 16);

    // Pattern 2 with random beat gaps and 5-cycle ack latency.
    start(2'd2, 1'b0);
    serve_pass(1'b1, 5, -1, 1'b0);
    wait_done();
    check("walk_beat0", cap[0], 32'h0000_0001);
    check("walk_beat5", cap[5], 32'h0000_0020);
    check("walk_beat31", cap[31], 32'h8000_0000);
    check("gaps_err_cnt", err_cnt, 0);
    check("gaps_pass_cnt", pass_cnt, 1);

    // Looping: pattern change mid-pass takes effect only at the next pass.
    start(2'd2, 1'b1);
    pass_pat.push_back(0);
    pass_pat.push_back(0);
    fork
      serve_pass(1'b0, 0, -1, 1'b0);
      begin repeat (20) tick(); pattern_sel = 2'd0; end
    join
    serve_pass(1'b0, 0, -1, 1'b0);
    fork
      serve_pass(1'b0, 0, -1, 1'b0);
      begin repeat (10) tick(); loop_en = 1'b0; end
    join
    wait_done();
    check("loop_pass_cnt", pass_cnt, 3);
    check("loop_err_cnt", err_cnt, 0);
    check("loop_beat31", cap[31], 32'h001F_001F);

    // Asynchronous reset in the middle of a write burst, then a clean restart.
    start(2'd0, 1'b0);
    wait_req(1'b0);
    app.wr_ack = 1'b1; tick(); app.wr_ack = 1'b0;
    repeat (3) begin app.wr_data_req = 1'b1; tick(); app.wr_data_req = 1'b0; end
    #2 sys_rst = 1'b1;
    #1 check_zero("midrst");
    tick();
    sys_rst = 1'b0;
    t = 0;
    while (app.wr_req !== 1'b1 && t < 50) begin tick(); t++; end
    check("restart_delay_min", (t >= int'(WRD)), 1);
    check("restart_delay_max", (t <= int'(WRD) + 3), 1);
    serve_pass(1'b0, 0, -1, 1'b0);
    wait_done();
    check("restart_beat0", cap[0], 32'h0000_0000);
    check("restart_pass_cnt", pass_cnt, 1);
    check("restart_err_cnt", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr2_traffic_gen.md
Name: ddr2_traffic_gen

Overview:
- Parametrised write/read-back traffic generator and checker for the DDR2 controller user interface.
- Successor to the fixed-pattern, single-pass generator in the board top. Adds:
  - configurable burst count, address stride and base address;
  - four runtime-selectable data patterns;
  - looping passes;
  - an error counter with first-failure capture.
- Sits between the DDR2 controller app port and the status LEDs/UART reporting logic.

Parameters:
ADDR_WIDTH, 26, controller app address width (ROW+COL+BA bits)
DATA_WIDTH, 32, app data width; must be a multiple of 16
BURST_LEN, 8, beats per app burst (1..255)
NUM_BURSTS, 64, bursts per pass (>=1)
BASE_ADDR, 0, first burst address
ADDR_STEP, 16, address increment per burst
WR_DELAY, 100, idle cycles before write phase
RD_DELAY, 200, idle cycles between write and read phase

Ports:
sys_clk  in  1  single clock
sys_rst  in  1  asynchronous reset, active-high
init_done  in  1  controller calibration/init complete
pattern_sel  in  2  0=incrementing, 1=LFSR16, 2=walking-one, 3=inverted incrementing
loop_en  in  1  1=repeat passes indefinitely
wr_req  out  1  write burst request
wr_addr  out  ADDR_WIDTH  write burst address
wr_ack  in  1  one-cycle accept of wr_req
wr_data_req  in  1  controller consumes current wr_data this cycle
wr_data  out  DATA_WIDTH  write beat data
rd_req  out  1  read burst request
rd_addr  out  ADDR_WIDTH  read burst address
rd_ack  in  1  one-cycle accept of rd_req
rd_data_valid  in  1  rd_data beat valid
rd_data  in  DATA_WIDTH  read beat data
wr_over  out  1  sticky: at least one write phase completed
rd_error  out  1  sticky: any mismatch seen
err_cnt  out  16  mismatching beats, saturates at 16'hFFFF
first_err_addr  out  ADDR_WIDTH  burst address of first mismatch
pass_cnt  out  16  completed passes, wraps
busy  out  1  high whenever state != IDLE and != DONE

Behaviour:
- Reset (async, sys_rst=1): all outputs 0, state IDLE, counters 0, LFSR=16'hACE1.
- States: IDLE -> WR_WAIT -> WR_REQ -> WR_DATA -> (WR_REQ | RD_WAIT) -> RD_REQ -> RD_DATA -> (RD_REQ | PASS_END) -> (WR_WAIT | DONE).
- IDLE:
  - init_done is sampled only here. When it is 1: latch pattern_sel, clear the burst index, reset the beat index and LFSR, go to WR_WAIT.
  - init_done falling in any later state is ignored.
- WR_WAIT / RD_WAIT: count WR_DELAY / RD_DELAY cycles, then advance. A delay of 0 advances on the next cycle.
- WR_REQ:
  - wr_req=1, wr_addr = BASE_ADDR + k*ADDR_STEP, mod 2^ADDR_WIDTH (k = burst index).
  - Hold until wr_ack=1, then drop wr_req on the next cycle and go to WR_DATA.
- WR_DATA:
  - wr_data always shows the current beat.
  - On each wr_data_req=1 cycle: advance to the next beat next cycle and count the beat. Gaps are allowed.
  - After BURST_LEN beats: k++. Go to WR_REQ if k<NUM_BURSTS; otherwise set wr_over=1, reset the beat index and LFSR, go to RD_WAIT.
- RD_REQ / RD_DATA: same handshake as the write side.
  - Each rd_data_valid beat is compared against the expected beat generated by the identical sequence.
  - Mismatch: err_cnt++ (saturating), rd_error=1. If this is the first error since reset, first_err_addr = current rd_addr.
  - rd_data_valid outside RD_DATA is ignored.
- PASS_END: pass_cnt++ (wraps). If loop_en=1: re-latch pattern_sel, reset k/beat/LFSR, go to WR_WAIT. Otherwise go to DONE.
- DONE: terminal until reset. busy=0.
- Beat data, with n = global beat index within the pass (16-bit, wraps):
  - pattern 0: n replicated.
  - pattern 1: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, replicated. Steps once per beat; seed 16'hACE1.
  - pattern 2: 1 << (n mod DATA_WIDTH).
  - pattern 3: ~(n replicated).
- Simultaneous events:
  - wr_ack and wr_data_req in the same cycle: the ack is taken; wr_data_req is counted only in WR_DATA. The controller never issues data_req before ack.
  - Error counting continues across passes; err_cnt and rd_error clear only on reset.

Decomposition:
- Package ddr2_tg_pkg: state enum, pattern codes (PAT_INC, PAT_LFSR, PAT_WALK, PAT_INV), LFSR seed and taps.
- One sub-module, ddr2_tg_pattern: given pattern, beat index, LFSR state and an advance/reset strobe, produces beat data.
- Instantiate ddr2_tg_pattern twice: once for the write generator, once for the expected-data generator.

Test Plan:
- Pattern 0, BURST_LEN=8, NUM_BURSTS=4, ideal responder:
  - write beats 0..31 at addresses 0,16,32,48;
  - wr_over=1, rd_error=0, pass_cnt=1, DONE.
- Pattern 1: first four write beats are LFSR states from 16'hACE1, replicated; read-back matches, err_cnt=0.
- Responder corrupts bit 3 of beat 2 in burst 1 (pattern 3) -> err_cnt=1, rd_error=1, first_err_addr=16.
- Random wr_data_req / rd_data_valid gaps and wr_ack delayed by 5 cycles -> identical data sequence, no errors.
- loop_en=1 for 3 passes, pattern_sel changed 2 -> 0 mid-pass -> new pattern applies only from the next pass; pass_cnt=3.
- sys_rst asserted during WR_DATA -> all outputs 0 immediately; after release with init_done=1, a clean restart after WR_DELAY cycles.
